branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port d_valid, input, 1: D-stage holds a valid instruction.
REQ-004 SHALL have port d_br_op, input, 3: 3'b001 beq, 3'b010 bne; any other value is "no branch".
REQ-005 SHALL have port d_pc, input, 32: PC of D-stage instruction.
REQ-006 SHALL have port d_imm16, input, 16: branch offset field.
REQ-007 SHALL have ports rs_val / rt_val, input, 32 each: forwarded operand values.
REQ-008 SHALL have ports rs_ready / rt_ready, input, 1 each: operand valid (no outstanding producer).
REQ-009 SHALL have port stall_ext, input, 1: stall from other hazard sources (e.g. MDU busy).
REQ-010 SHALL have port flush, input, 1: exception/eret pipeline flush.
REQ-011 SHALL have ports cmp_srca / cmp_srcb, output, 32 each, and cmp_op, output, 3: drive the comparator.
REQ-012 SHALL have port cmp_allow, input, 1: comparator result (condition true).
REQ-013 SHALL have port npc_sel, output, 1: redirect fetch to npc_target this cycle.
REQ-014 SHALL have port npc_target, output, 32: branch target.
REQ-015 SHALL have port stall_d, output, 1: freeze PC/F/D due to branch operand hazard.
REQ-016 SHALL have port ds_flag, output, 1: D-stage instruction is a delay-slot instruction (for CP0 BD).
REQ-017 SHALL have ports br_total_cnt / br_taken_cnt, output, 32 each: resolved / taken branch counters.

Function
REQ-018 SHALL define br_in_d = d_valid && d_br_op in {001,010}.
REQ-019 SHALL drive cmp_srca=rs_val, cmp_srcb=rt_val, cmp_op=d_br_op when br_in_d, else cmp_op=3'b000 (operand outputs don't-care).
REQ-020 SHALL compute npc_target = d_pc + 4 + (sign_extend(d_imm16) << 2), modulo 2^32 (wrap, no overflow flag).
REQ-021 SHALL assert stall_d combinationally when br_in_d && !(rs_ready && rt_ready) && !flush.
REQ-022 SHALL define resolve = br_in_d && rs_ready && rt_ready && !stall_ext && !flush.
REQ-023 SHALL assert npc_sel = resolve && cmp_allow (zero-cycle decision in D; delay slot always executes).
REQ-024 SHALL implement FSM IDLE / WAIT / SLOT: IDLE->WAIT when stall_d; IDLE->SLOT and WAIT->SLOT on resolve; WAIT stays while stall_d or stall_ext; SLOT->IDLE when d_valid && !stall_d && !stall_ext (slot instruction leaves D), else holds.
REQ-025 SHALL, in SLOT, if the slot instruction is itself a branch that resolves, go SLOT->SLOT and redirect normally.
REQ-026 SHALL make ds_flag registered: 1 exactly while state == SLOT, else 0.
REQ-027 SHALL increment br_total_cnt by 1 on each resolve cycle, and br_taken_cnt by 1 when resolve && cmp_allow; both wrap 0xFFFFFFFF->0.
REQ-028 SHALL on flush (highest priority) force next state IDLE, suppress npc_sel, stall_d and counter updates in that cycle.
REQ-029 SHALL not increment counters or redirect during any stall cycle; a stalled branch is counted once on its resolving cycle.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, set state IDLE, ds_flag 0, br_total_cnt 0, br_taken_cnt 0; reset dominates flush and all inputs.
REQ-031 SHALL keep combinational outputs purely input-derived during reset; reset mid-WAIT or mid-SLOT returns to IDLE with no pending redirect.

Verification
REQ-032 SHALL verify: beq, d_pc=0x00003000, imm=0x0004, operands ready, cmp_allow=1 -> same cycle npc_sel=1, npc_target=0x00003014; next cycle ds_flag=1; counters 1/1.
REQ-033 SHALL verify: bne, imm=0xFFFF, d_pc=0x00003000, cmp_allow=0 -> npc_sel=0, npc_target=0x00003000; total=1, taken=0; ds_flag=1 next cycle.
REQ-034 SHALL verify: beq with rt_ready=0 for 3 cycles then 1 -> stall_d=1 for exactly 3 cycles, npc_sel only on 4th, counters +1 once.
REQ-035 SHALL verify: d_pc=0xFFFFFFFC, imm=0x0001 -> npc_target=0x00000004 (wrap).
REQ-036 SHALL verify: flush asserted in resolving cycle -> npc_sel=0, counters unchanged, ds_flag=0 next cycle; reset in SLOT -> ds_flag=0, counters 0 next cycle.
REQ-037 SHALL verify: slot instruction held by stall_ext for 2 cycles -> ds_flag stays 1 until it leaves D, then 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - D-stage branch resolution, redirect, delay-slot tracking and branch counters
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   d_valid, d_br_op           D-stage instruction valid and branch kind (001 beq, 010 bne)
//   d_pc, d_imm16              D-stage PC and branch offset field
//   rs_val/rt_val              forwarded operand values
//   rs_ready/rt_ready          operand valid flags
//   stall_ext, flush           external stall and pipeline flush
//   cmp_srca/cmp_srcb/cmp_op   comparator drive
//   cmp_allow                  comparator result
//   npc_sel, npc_target        fetch redirect and branch target
//   stall_d                    branch operand hazard stall
//   ds_flag                    D-stage instruction sits in a delay slot
//   br_total_cnt/br_taken_cnt  resolved / taken branch counters

module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [2:0]  d_br_op,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic        stall_ext,
    input  logic        flush,
    output logic [31:0] cmp_srca,
    output logic [31:0] cmp_srcb,
    output logic [2:0]  cmp_op,
    input  logic        cmp_allow,
    output logic        npc_sel,
    output logic [31:0] npc_target,
    output logic        stall_d,
    output logic        ds_flag,
    output logic [31:0] br_total_cnt,
    output logic [31:0] br_taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SLOT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ds_flag_q, ds_flag_d;
    logic [31:0] total_q, total_d;
    logic [31:0] taken_q, taken_d;

    logic br_in_d;
    logic ops_ready;
    logic resolve;

    assign br_in_d   = d_valid && ((d_br_op == 3'b001) || (d_br_op == 3'b010));
    assign ops_ready = rs_ready && rt_ready;
    assign resolve   = br_in_d && ops_ready && !stall_ext && !flush;

    assign cmp_srca   = rs_val;
    assign cmp_srcb   = rt_val;
    assign cmp_op     = br_in_d ? d_br_op : 3'b000;
    // Word offset, sign-extended and scaled to bytes; the sum wraps at 2^32.
    assign npc_target = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    assign stall_d    = br_in_d && !ops_ready && !flush;
    assign npc_sel    = resolve && cmp_allow;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        taken_d = taken_q;

        if (resolve) begin
            total_d = total_q + 32'd1;
            if (cmp_allow) begin
                taken_d = taken_q + 32'd1;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (resolve)      state_d = ST_SLOT;
                    else if (stall_d) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (resolve)                     state_d = ST_SLOT;
                    else if (stall_d || stall_ext)   state_d = ST_WAIT;
                    else                             state_d = ST_IDLE;
                end
                ST_SLOT: begin
                    // A branch sitting in the slot opens a fresh slot of its own.
                    if (resolve)                                  state_d = ST_SLOT;
                    else if (d_valid && !stall_d && !stall_ext)   state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ds_flag_d = (state_d == ST_SLOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ds_flag_q <= 1'b0;
            total_q   <= 32'd0;
            taken_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            ds_flag_q <= ds_flag_d;
            total_q   <= total_d;
            taken_q   <= taken_d;
        end
    end

    assign ds_flag      = ds_flag_q;
    assign br_total_cnt = total_q;
    assign br_taken_cnt = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl

module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [2:0]  d_br_op;
    logic [31:0] d_pc;
    logic [15:0] d_imm16;
    logic [31:0] rs_val, rt_val;
    logic        rs_ready, rt_ready;
    logic        stall_ext, flush;
    logic [31:0] cmp_srca, cmp_srcb;
    logic [2:0]  cmp_op;
    logic        cmp_allow;
    logic        npc_sel;
    logic [31:0] npc_target;
    logic        stall_d;
    logic        ds_flag;
    logic [31:0] br_total_cnt, br_taken_cnt;

    int checks   = 0;
    int failures = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_br_op      (d_br_op),
        .d_pc         (d_pc),
        .d_imm16      (d_imm16),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .rs_ready     (rs_ready),
        .rt_ready     (rt_ready),
        .stall_ext    (stall_ext),
        .flush        (flush),
        .cmp_srca     (cmp_srca),
        .cmp_srcb     (cmp_srcb),
        .cmp_op       (cmp_op),
        .cmp_allow    (cmp_allow),
        .npc_sel      (npc_sel),
        .npc_target   (npc_target),
        .stall_d      (stall_d),
        .ds_flag      (ds_flag),
        .br_total_cnt (br_total_cnt),
        .br_taken_cnt (br_taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                              input logic allow);
        d_valid   = 1'b1;
        d_br_op   = op;
        d_pc      = pc;
        d_imm16   = imm;
        rs_ready  = 1'b1;
        rt_ready  = 1'b1;
        cmp_allow = allow;
        #1;
    endtask

    task automatic set_plain();
        d_valid   = 1'b1;
        d_br_op   = 3'b000;
        cmp_allow = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; d_valid = 1'b0; d_br_op = 3'b000; d_pc = 32'h0; d_imm16 = 16'h0;
        rs_val = 32'h1111_2222; rt_val = 32'h3333_4444; rs_ready = 1'b1; rt_ready = 1'b1;
        stall_ext = 1'b0; flush = 1'b0; cmp_allow = 1'b0;
        step(); step();
        reset = 1'b0;
        check("reset_ds_flag", {31'd0, ds_flag}, 32'd0);
        check("reset_total", br_total_cnt, 32'd0);
        check("reset_taken", br_taken_cnt, 32'd0);

        // beq taken, zero-cycle redirect
        set_branch(3'b001, 32'h0000_3000, 16'h0004, 1'b1);
        check("beq_npc_sel", {31'd0, npc_sel}, 32'd1);
        check("beq_target", npc_target, 32'h0000_3014);
        check("beq_cmp_op", {29'd0, cmp_op}, 32'd1);
        check("beq_srca", cmp_srca, 32'h1111_2222);
        check("beq_srcb", cmp_srcb, 32'h3333_4444);
        check("beq_stall_d", {31'd0, stall_d}, 32'd0);
        step();
        check("beq_ds_flag", {31'd0, ds_flag}, 32'd1);
        check("beq_total", br_total_cnt, 32'd1);
        check("beq_taken", br_taken_cnt, 32'd1);
        set_plain();
        step();
        check("beq_slot_leave", {31'd0, ds_flag}, 32'd0);

        // bne not taken, negative offset
        set_branch(3'b010, 32'h0000_3000, 16'hFFFF, 1'b0);
        check("bne_npc_sel", {31'd0, npc_sel}, 32'd0);
        check("bne_target", npc_target, 32'h0000_3000);
        check("bne_cmp_op", {29'd0, cmp_op}, 32'd2);
        step();
        check("bne_ds_flag", {31'd0, ds_flag}, 32'd1);
        check("bne_total", br_total_cnt, 32'd2);
        check("bne_taken", br_taken_cnt, 32'd1);
        set_plain();
        step();
        check("bne_slot_leave", {31'd0, ds_flag}, 32'd0);

        // beq waiting on rt for three cycles
        set_branch(3'b001, 32'h0000_4000, 16'h0010, 1'b1);
        rt_ready = 1'b0;
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall_d) stall_cycles++;
            check("hz_no_redirect", {31'd0, npc_sel}, 32'd0);
            step();
            check("hz_ds_flag", {31'd0, ds_flag}, 32'd0);
            check("hz_total_hold", br_total_cnt, 32'd2);
        end
        check("hz_stall_cycles", stall_cycles, 32'd3);
        rt_ready = 1'b1;
        #1;
        check("hz_release_stall", {31'd0, stall_d}, 32'd0);
        check("hz_release_sel", {31'd0, npc_sel}, 32'd1);
        check("hz_target", npc_target, 32'h0000_4044);
        step();
        check("hz_ds_flag_slot", {31'd0, ds_flag}, 32'd1);
        check("hz_total", br_total_cnt, 32'd3);
        check("hz_taken", br_taken_cnt, 32'd2);
        set_plain();
        step();
        check("hz_slot_leave", {31'd0, ds_flag}, 32'd0);

        // target wrap; no branch in D
        d_valid = 1'b0; d_br_op = 3'b001; d_pc = 32'hFFFF_FFFC; d_imm16 = 16'h0001; cmp_allow = 1'b1;
        #1;
        check("wrap_target", npc_target, 32'h0000_0004);
        check("nobr_cmp_op", {29'd0, cmp_op}, 32'd0);
        check("nobr_npc_sel", {31'd0, npc_sel}, 32'd0);
        step();
        check("nobr_total", br_total_cnt, 32'd3);

        // flush in the resolving cycle
        set_branch(3'b001, 32'h0000_3000, 16'h0004, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_npc_sel", {31'd0, npc_sel}, 32'd0);
        rt_ready = 1'b0;
        #1;
        check("flush_stall_d", {31'd0, stall_d}, 32'd0);
        rt_ready = 1'b1;
        step();
        check("flush_ds_flag", {31'd0, ds_flag}, 32'd0);
        check("flush_total", br_total_cnt, 32'd3);
        check("flush_taken", br_taken_cnt, 32'd2);
        flush = 1'b0;

        // external stall blocks resolution
        stall_ext = 1'b1;
        #1;
        check("sext_npc_sel", {31'd0, npc_sel}, 32'd0);
        step();
        check("sext_total", br_total_cnt, 32'd3);
        check("sext_ds_flag", {31'd0, ds_flag}, 32'd0);
        stall_ext = 1'b0;
        #1;

        // branch in the slot resolves: SLOT -> SLOT
        check("chain1_npc_sel", {31'd0, npc_sel}, 32'd1);
        step();
        check("chain1_ds_flag", {31'd0, ds_flag}, 32'd1);
        set_branch(3'b010, 32'h0000_3004, 16'h0002, 1'b1);
        check("chain2_npc_sel", {31'd0, npc_sel}, 32'd1);
        check("chain2_target", npc_target, 32'h0000_3010);
        step();
        check("chain2_ds_flag", {31'd0, ds_flag}, 32'd1);
        check("chain_total", br_total_cnt, 32'd5);
        check("chain_taken", br_taken_cnt, 32'd4);

        // slot instruction held by stall_ext
        set_plain();
        stall_ext = 1'b1;
        step();
        check("slot_hold1", {31'd0, ds_flag}, 32'd1);
        step();
        check("slot_hold2", {31'd0, ds_flag}, 32'd1);
        stall_ext = 1'b0;
        step();
        check("slot_release", {31'd0, ds_flag}, 32'd0);

        // reset while in SLOT, with a resolving branch still presented
        set_branch(3'b001, 32'h0000_3000, 16'h0004, 1'b1);
        step();
        check("pre_reset_ds_flag", {31'd0, ds_flag}, 32'd1);
        check("pre_reset_total", br_total_cnt, 32'd6);
        reset = 1'b1;
        step();
        check("rst_slot_ds_flag", {31'd0, ds_flag}, 32'd0);
        check("rst_slot_total", br_total_cnt, 32'd0);
        check("rst_slot_taken", br_taken_cnt, 32'd0);
        reset = 1'b0;
        set_plain();
        step();
        check("post_reset_ds_flag", {31'd0, ds_flag}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
